ws2812_frame_sequencer: RTL and testbench

//   Feeds the WS2812 serial bit transmitter from a pixel frame buffer. On a frame request it

---
 rtl/ws2812_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer
//   Fetches 24-bit GRB pixels from a synchronous-read frame buffer and presents them
//   MSB-first on tx_data, advancing one bit per rising edge of the transmitter's tx_done.
//   After the last bit, tx_data is held low for LATCH_CYCLES clocks so the strip latches.
//   frame_done then pulses for one clock.
//   Optional feature macro: WS_BRIGHTNESS_EN. When it is defined, each 8-bit channel is
//   scaled by brightness/256 as the pixel enters the shift register.
//
//   pix_rd_en / pix_rdata handshake:
//     pix_rd_en is a one-clock read strobe qualified by pix_addr.
//     pix_rdata is valid exactly one clock after the strobe.
//     There is no back-pressure; pix_addr holds its value while pix_rd_en is low.
//
//   state_dbg exposes the FSM state (0 IDLE, 1 FETCH, 2 LOAD, 3 STREAM, 4 LATCH).
module ws2812_frame_sequencer #(
  parameter int N_PIXELS     = 128,
  parameter int ADDR_W       = 7,
  parameter int BPP          = 24,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd_en,
  input  logic [BPP-1:0]    pix_rdata,
  input  logic [7:0]        brightness,
  input  logic              tx_done,
  output logic              tx_data,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state_dbg
);

  localparam int CW = $clog2(BPP);
  localparam int LW = $clog2(LATCH_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIXELS - 1);
  localparam logic [LW-1:0]     LAT_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0]     TOP_BIT  = CW'(BPP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_LATCH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BPP-1:0]    shift_q;
  logic [BPP-1:0]    hold_q;
  logic [CW-1:0]     bit_cnt;
  logic [ADDR_W-1:0] idx;
  logic [LW-1:0]     lat_cnt;
  logic              tx_done_q;
  logic              pf_wait;

  logic              tx_edge;
  logic              idx_last;
  logic              lat_tc;
  logic [ADDR_W-1:0] idx_inc;
  logic [ADDR_W-1:0] idx_inc2;
  logic [BPP-1:0]    load_word;
  logic [BPP-1:0]    hold_word;

  assign tx_edge   = tx_done & ~tx_done_q;
  assign idx_last  = (idx == LAST_IDX);
  assign lat_tc    = (lat_cnt == LAT_LAST);
  assign idx_inc   = idx + ADDR_W'(1);
  assign idx_inc2  = idx + ADDR_W'(2);
  assign state_dbg = state_q;

`ifdef WS_BRIGHTNESS_EN
  // Per-channel (ch*brightness)>>8, sampled at the moment a pixel enters the shift register.
  function automatic logic [BPP-1:0] scale_px(input logic [BPP-1:0] w, input logic [7:0] b);
    logic [15:0] g, r, bl;
    g  = {8'd0, w[23:16]} * {8'd0, b};
    r  = {8'd0, w[15:8]}  * {8'd0, b};
    bl = {8'd0, w[7:0]}   * {8'd0, b};
    return {g[15:8], r[15:8], bl[15:8]};
  endfunction

  assign load_word = scale_px(pix_rdata, brightness);
  assign hold_word = scale_px(hold_q, brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign load_word = pix_rdata;
  assign hold_word = hold_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; only a tx_done edge on the final bit of the final pixel leaves STREAM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (tx_edge && (bit_cnt == '0) && idx_last) state_d = S_LATCH;
      S_LATCH:  if (lat_tc) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: fetch/prefetch strobes, shift register, counters and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_addr   <= '0;
      pix_rd_en  <= 1'b0;
      tx_data    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      bit_cnt    <= '0;
      idx        <= '0;
      lat_cnt    <= '0;
      tx_done_q  <= 1'b0;
      pf_wait    <= 1'b0;
    end else begin
      tx_done_q  <= tx_done;
      frame_done <= 1'b0;
      pix_rd_en  <= 1'b0;
      // A strobe issued while streaming is a prefetch; its data lands one clock later.
      pf_wait    <= pix_rd_en && (state_q == S_STREAM);
      if (pf_wait) hold_q <= pix_rdata;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            idx       <= '0;
            pix_rd_en <= 1'b1;
            pix_addr  <= '0;
          end
        end
        S_LOAD: begin
          shift_q <= load_word;
          tx_data <= load_word[BPP-1];
          bit_cnt <= TOP_BIT;
          if (!idx_last) begin
            pix_rd_en <= 1'b1;
            pix_addr  <= idx_inc;
          end
        end
        S_STREAM: begin
          if (tx_edge) begin
            if (bit_cnt != '0) begin
              shift_q <= shift_q << 1;
              tx_data <= shift_q[BPP-2];
              bit_cnt <= bit_cnt - CW'(1);
            end else if (!idx_last) begin
              shift_q <= hold_word;
              tx_data <= hold_word[BPP-1];
              bit_cnt <= TOP_BIT;
              idx     <= idx_inc;
              if (idx_inc != LAST_IDX) begin
                pix_rd_en <= 1'b1;
                pix_addr  <= idx_inc2;
              end
            end else begin
              tx_data <= 1'b0;
              lat_cnt <= '0;
            end
          end
        end
        S_LATCH: begin
          if (lat_tc) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            lat_cnt    <= '0;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// tb_ws2812_frame_sequencer
//   Randomized bench for ws2812_frame_sequencer. A 48-pixel frame keeps runtime short.
//   The bench models the frame buffer and the transmitter. Expected bit streams come from a
//   per-pixel model of the GRB/MSB-first rules, with optional brightness scaling.
module tb_ws2812_frame_sequencer;

  localparam int NP   = 48;
  localparam int AW   = 6;
  localparam int BPP  = 24;
  localparam int LC   = 2500;
  localparam int NBIT = NP * BPP;
`ifdef WS_BRIGHTNESS_EN
  localparam bit BRI_EN = 1'b1;
`else
  localparam bit BRI_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, pix_rd_en, tx_done, tx_data, busy, frame_done;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_rdata = '0;
  logic [7:0]    brightness;
  logic [2:0]    state_dbg;

  ws2812_frame_sequencer #(
    .N_PIXELS(NP), .ADDR_W(AW), .BPP(BPP), .LATCH_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_addr(pix_addr), .pix_rd_en(pix_rd_en), .pix_rdata(pix_rdata),
    .brightness(brightness), .tx_done(tx_done), .tx_data(tx_data),
    .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // ---------------- frame buffer model ----------------
  logic [23:0]   mem [NP];
  logic [AW-1:0] addr_log[$];
  always @(posedge clk) begin
    if (pix_rd_en) begin
      pix_rdata <= mem[pix_addr];
      addr_log.push_back(pix_addr);
    end
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model_px(input logic [23:0] w, input logic [7:0] b);
    int g, r, bl;
    g  = (int'(w[23:16]) * int'(b)) / 256;
    r  = (int'(w[15:8])  * int'(b)) / 256;
    bl = (int'(w[7:0])   * int'(b)) / 256;
    if (BRI_EN) return {g[7:0], r[7:0], bl[7:0]};
    return w;
  endfunction

  // Pixel p begins after bit p*24-1; brightness set before bit change_bit affects later pixels.
  task automatic build_expected(input logic [7:0] b0, input logic [7:0] b1, input int change_bit);
    logic [23:0] w;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      w = model_px(mem[p], (change_bit >= 0 && p * BPP > change_bit) ? b1 : b0);
      for (int i = BPP - 1; i >= 0; i--) exp_q.push_back(w[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_frame(input bit with_edge);
    addr_log.delete();
    @(negedge clk);
    check("done_one_clk", frame_done, 1'b0);
    start = 1'b1;
    if (with_edge) tx_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", busy, 1'b1);
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic latch_check();
    int  k    = 0;
    int  bad  = 0;
    bit  seen = 1'b0;
    while (k < LC + 200 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 2) tx_done = 1'b0;
      if (frame_done === 1'b1) seen = 1'b1;
      else if (tx_data !== 1'b0 || busy !== 1'b1) bad++;
    end
    tx_done = 1'b0;
    check("latch_seen", seen, 1'b1);
    check("latch_len", k, LC + 1);
    check("latch_low", bad, 0);
    check("busy_fall", busy, 1'b0);
  endtask

  task automatic run_bits(input int abort_bit, input int long_bit, input int change_bit,
                          input logic [7:0] b1);
    int low, hold;
    for (int b = 0; b < NBIT; b++) begin
      low = $urandom_range(2, 4);
      repeat (low) @(negedge clk);
      if (b == change_bit) brightness = b1;
      if (b == abort_bit) begin
        check("busy_mid", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_addr", pix_addr, 0);
        check("abort_rd_en", pix_rd_en, 1'b0);
        check("abort_tx_data", tx_data, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", frame_done, 1'b0);
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      check($sformatf("bit%0d", b), tx_data, exp_q.pop_front());
      hold = (b >= long_bit && b < long_bit + 3) ? 6 : $urandom_range(1, 3);
      tx_done = 1'b1;
      if (b == NBIT - 1) begin
        latch_check();
        return;
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        start = (b == long_bit && h == 2);
      end
      start   = 1'b0;
      tx_done = 1'b0;
    end
  endtask

  task automatic check_addrs();
    check("addr_count", addr_log.size(), NP);
    for (int i = 0; i < NP && i < addr_log.size(); i++)
      check($sformatf("addr%0d", i), addr_log[i], i);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b_new;
    rst = 1'b1; start = 1'b0; tx_done = 1'b0; brightness = 8'd255;
    for (int p = 0; p < NP; p++) mem[p] = 24'($urandom);
    mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF; mem[3] = 24'hA5A5A5;

    repeat (3) @(negedge clk);
    check("rst_addr", pix_addr, 0);
    check("rst_rd_en", pix_rd_en, 1'b0);
    check("rst_tx_data", tx_data, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    rst = 1'b0;

    // tx_done edges while idle must not start anything
    repeat (3) begin
      @(negedge clk); tx_done = 1'b1;
      repeat (2) @(negedge clk);
      tx_done = 1'b0;
    end
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_reads", addr_log.size(), 0);

    // Frame A: abort with reset mid-pixel 40
    build_expected(8'd255, 8'd255, -1);
    start_frame(1'b0);
    run_bits(40 * BPP + 5, -10, -1, 8'd255);

    // Frame B: restart from pixel 0, start coinciding with a tx_done edge, start pulse mid-stream
    build_expected(8'd255, 8'd255, -1);
    start_frame(1'b1);
    run_bits(-1, 100, -1, 8'd255);
    check_addrs();

    // Frame C: back-to-back start, brightness 128 then changed during pixel 2
    for (int p = 0; p < NP; p++) mem[p] = 24'($urandom);
    mem[0] = 24'hFF8040;
    brightness = 8'd128;
    b_new = 8'($urandom_range(0, 255));
    build_expected(8'd128, b_new, 60);
    start_frame(1'b0);
    run_bits(-1, -10, 60, b_new);
    check_addrs();

    // Frame D: fully random pixels and brightness after some idle time
    for (int p = 0; p < NP; p++) mem[p] = 24'($urandom);
    brightness = 8'($urandom_range(0, 255));
    repeat ($urandom_range(3, 20)) @(negedge clk);
    build_expected(brightness, brightness, -1);
    start_frame(1'b0);
    run_bits(-1, -10, -1, brightness);
    check_addrs();

    repeat (3) @(negedge clk);
    check("final_busy", busy, 1'b0);
    check("final_done", frame_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
